// File: rtl/framebuffer_writer.sv
// Camera capture into a 176x144 greyscale framebuffer: crops oversize frames, flags short lines.
// Optional double-buffering of the write bank is enabled by defining FBW_BANK_SWAP_EN.
module framebuffer_writer #(
  parameter int unsigned FRAMEBUF_WIDTH  = 176,
  parameter int unsigned FRAMEBUF_HEIGHT = 144
) (
  input  logic        cam_clk_25_i,
  input  logic        reset_i,
  input  logic        fval_i,
  input  logic        lval_i,
  input  logic [7:0]  pix_in_i,
  output logic [15:0] wr_addr_o,
  output logic [7:0]  wr_data_o,
  output logic        wr_en_o,
  output logic        frame_done_o,
  output logic        rd_bank_o,
  output logic        line_err_o
);

  localparam int unsigned COL_W = $clog2(FRAMEBUF_WIDTH + 1);
  localparam int unsigned ROW_W = $clog2(FRAMEBUF_HEIGHT + 1);
  localparam logic [COL_W-1:0] COL_MAX   = COL_W'(FRAMEBUF_WIDTH);
  localparam logic [ROW_W-1:0] ROW_MAX   = ROW_W'(FRAMEBUF_HEIGHT);
  localparam logic [14:0]      LINE_STEP = 15'(FRAMEBUF_WIDTH);

  typedef enum logic [1:0] {
    ST_SYNC    = 2'd0,
    ST_IDLE    = 2'd1,
    ST_CAPTURE = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [14:0]      line_base_q, line_base_d;
  logic             lval_prev_q, lval_prev_d;

  logic [15:0] wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        wr_en_q, wr_en_d;
  logic        frame_done_q, frame_done_d;
  logic        line_err_q, line_err_d;
  logic        wr_bank;

  logic in_capture;
  logic pix_accept;
  logic pix_write;
  logic line_end;
  logic frame_end;
  logic short_line;

  // State register
  always_ff @(posedge cam_clk_25_i) begin
    if (reset_i) begin
      state_q <= ST_SYNC;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_SYNC:    if (!fval_i) state_d = ST_IDLE;
      ST_IDLE:    if (fval_i)  state_d = ST_CAPTURE;
      ST_CAPTURE: if (!fval_i) state_d = ST_IDLE;
      default:    state_d = ST_SYNC;
    endcase
  end

  // State-dependent event decode
  always_comb begin
    in_capture = (state_q == ST_CAPTURE);
    pix_accept = in_capture && fval_i && lval_i;
    pix_write  = pix_accept && (col_q < COL_MAX) && (row_q < ROW_MAX);
    frame_end  = in_capture && !fval_i;
    // lval_prev_q only records lval seen inside a capturing frame, so stray
    // lval activity in SYNC/IDLE can never fake a line end.
    line_end   = in_capture && fval_i && !lval_i && lval_prev_q;
    short_line = (line_end || frame_end) && (col_q != '0) && (col_q < COL_MAX);
  end

  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    line_base_d = line_base_q;
    lval_prev_d = pix_accept;
    if (frame_end) begin
      col_d       = '0;
      row_d       = '0;
      line_base_d = '0;
    end else if (line_end) begin
      col_d = '0;
      if (row_q < ROW_MAX) begin
        row_d       = row_q + 1'b1;
        line_base_d = line_base_q + LINE_STEP;
      end
    end else if (pix_write) begin
      col_d = col_q + 1'b1;
    end
  end

  always_comb begin
    wr_en_d      = pix_write;
    wr_data_d    = wr_data_q;
    wr_addr_d    = wr_addr_q;
    if (pix_write) begin
      wr_data_d = pix_in_i;
      wr_addr_d = {wr_bank, line_base_q + 15'(col_q)};
    end
    frame_done_d = frame_end;
    line_err_d   = line_err_q | short_line;
  end

  always_ff @(posedge cam_clk_25_i) begin
    if (reset_i) begin
      col_q        <= '0;
      row_q        <= '0;
      line_base_q  <= '0;
      lval_prev_q  <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      wr_en_q      <= 1'b0;
      frame_done_q <= 1'b0;
      line_err_q   <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      line_base_q  <= line_base_d;
      lval_prev_q  <= lval_prev_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      wr_en_q      <= wr_en_d;
      frame_done_q <= frame_done_d;
      line_err_q   <= line_err_d;
    end
  end

`ifdef FBW_BANK_SWAP_EN
  // Swap on frame end so the reader only ever sees a completed frame.
  logic wr_bank_q, wr_bank_d;
  logic rd_bank_q, rd_bank_d;

  always_comb begin
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    if (frame_end) begin
      wr_bank_d = ~wr_bank_q;
      rd_bank_d = wr_bank_q;
    end
  end

  always_ff @(posedge cam_clk_25_i) begin
    if (reset_i) begin
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
    end else begin
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
    end
  end

  assign wr_bank   = wr_bank_q;
  assign rd_bank_o = rd_bank_q;
`else
  assign wr_bank   = 1'b0;
  assign rd_bank_o = 1'b0;
`endif

  assign wr_addr_o    = wr_addr_q;
  assign wr_data_o    = wr_data_q;
  assign wr_en_o      = wr_en_q;
  assign frame_done_o = frame_done_q;
  assign line_err_o   = line_err_q;

endmodule

// File: tb/tb_framebuffer_writer.sv
// Self-checking bench for framebuffer_writer: random pixel frames compared against
// an expected write list derived from row/column arithmetic.
module tb_framebuffer_writer;

  localparam int W = 176;
  localparam int H = 144;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fval = 1'b0;
  logic        lval = 1'b0;
  logic [7:0]  pix = 8'd0;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_en;
  logic        frame_done;
  logic        rd_bank;
  logic        line_err;

  framebuffer_writer dut (
    .cam_clk_25_i (clk),
    .reset_i      (rst),
    .fval_i       (fval),
    .lval_i       (lval),
    .pix_in_i     (pix),
    .wr_addr_o    (wr_addr),
    .wr_data_o    (wr_data),
    .wr_en_o      (wr_en),
    .frame_done_o (frame_done),
    .rd_bank_o    (rd_bank),
    .line_err_o   (line_err)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [23:0] act_q[$];
  logic [23:0] exp_q[$];
  int done_cnt = 0;
  int done_cyc = 0;
  int fall_cyc = 0;

  always @(negedge clk) begin
    if (wr_en === 1'b1) act_q.push_back({wr_addr, wr_data});
    if (frame_done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  // Reference state: sticky error flag and bank bookkeeping
  bit exp_err  = 1'b0;
  bit exp_bank = 1'b0;
  bit exp_rd   = 1'b0;
  int line_lens[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic compare_writes(input string name);
    int nbad = 0;
    int first = -1;
    int n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    check({name, " write count"}, act_q.size(), exp_q.size());
    for (int i = 0; i < n; i++) begin
      if (act_q[i] !== exp_q[i]) begin
        if (first < 0) first = i;
        nbad++;
      end
    end
    if (first >= 0)
      check($sformatf("%s writes (first bad idx %0d addr/data %h want %h)", name, first,
                      act_q[first], exp_q[first]), nbad, 0);
    else
      check({name, " write contents"}, nbad, 0);
    act_q.delete();
    exp_q.delete();
  endtask

  // Sends one frame of line_lens; optional truncation of the last line by fval
  // falling, and optional one-cycle reset at (abort_line, abort_pix).
  task automatic run_frame(input string name, input bit trunc, input int abort_line,
                           input int abort_pix);
    bit aborted = 1'b0;
    int d0 = done_cnt;
    int nl = line_lens.size();
    fval = 1'b1;
    lval = 1'b0;
    tick();
    tick();
    for (int r = 0; r < nl; r++) begin
      for (int j = 0; j < line_lens[r]; j++) begin
        lval = 1'b1;
        pix  = 8'($urandom);
        if (r == abort_line && j == abort_pix) begin
          rst      = 1'b1;
          aborted  = 1'b1;
          exp_err  = 1'b0;
          exp_bank = 1'b0;
          exp_rd   = 1'b0;
        end else if (!aborted && r < H && j < W) begin
          exp_q.push_back({exp_bank, 15'(r * W + j), pix});
        end
        tick();
        rst = 1'b0;
      end
      if (!aborted && r < H && line_lens[r] > 0 && line_lens[r] < W) exp_err = 1'b1;
      if (trunc && r == nl - 1) begin
        fval     = 1'b0;
        fall_cyc = cyc;
        tick();
        lval = 1'b0;
      end else begin
        lval = 1'b0;
        tick();
        tick();
      end
    end
    if (fval) begin
      fval     = 1'b0;
      fall_cyc = cyc;
    end
    repeat (4) tick();
    if (!aborted) begin
`ifdef FBW_BANK_SWAP_EN
      exp_rd   = exp_bank;
      exp_bank = ~exp_bank;
`endif
      check({name, " done latency"}, done_cyc - fall_cyc, 1);
    end
    check({name, " done pulses"}, done_cnt - d0, aborted ? 0 : 1);
    compare_writes(name);
    check({name, " line_err"}, line_err, exp_err);
    check({name, " rd_bank"}, rd_bank, exp_rd);
    line_lens.delete();
  endtask

  initial begin
    // Reset with fval high and lines streaming: nothing may be captured.
    rst  = 1'b1;
    fval = 1'b1;
    for (int i = 0; i < 6; i++) begin
      lval = i[0];
      pix  = 8'($urandom);
      tick();
    end
    check("reset wr_en", wr_en, 1'b0);
    check("reset wr_addr", wr_addr, 16'd0);
    check("reset wr_data", wr_data, 8'd0);
    check("reset frame_done", frame_done, 1'b0);
    check("reset rd_bank", rd_bank, 1'b0);
    check("reset line_err", line_err, 1'b0);
    rst = 1'b0;
    for (int r = 0; r < 3; r++) begin
      for (int j = 0; j < W; j++) begin
        lval = 1'b1;
        pix  = 8'($urandom);
        tick();
      end
      lval = 1'b0;
      tick();
      tick();
    end
    fval = 1'b0;
    repeat (4) tick();
    check("presync writes", act_q.size(), 0);
    check("presync done", done_cnt, 0);

    for (int r = 0; r < H; r++) line_lens.push_back(W);
    run_frame("full", 1'b0, -1, -1);

    line_lens = '{200, 176, 176};
    run_frame("crop_cols", 1'b0, -1, -1);

    for (int r = 0; r < 150; r++) line_lens.push_back(W);
    run_frame("crop_rows", 1'b0, -1, -1);

    for (int r = 0; r < 6; r++) line_lens.push_back(int'($urandom_range(150, 200)));
    run_frame("random_lines", 1'b0, -1, -1);

    line_lens = '{176, 60};
    run_frame("trunc_frame", 1'b1, -1, -1);

    line_lens = '{176, 176, 176};
    run_frame("after_trunc", 1'b0, -1, -1);

    line_lens = '{176, 176, 176};
    run_frame("reset_abort", 1'b0, 1, 40);

    line_lens = '{100, 176};
    run_frame("short_line", 1'b0, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
